// File: rtl/aes_mem_pkg.sv
// Shared definitions for the AES memory master: FSM states, word map, status layout.
package aes_mem_pkg;

  typedef enum logic [3:0] {
    IDLE, RD_KEY, RD_PT, CAP_PT, CORE_REQ, CORE_WAIT, WR_CT, WR_STAT, DONE
  } state_e;

  localparam logic [1:0] ADDR_KEY  = 2'd0;
  localparam logic [1:0] ADDR_PT   = 2'd1;
  localparam logic [1:0] ADDR_CT   = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  localparam int STAT_CNT_LSB   = 0;
  localparam int STAT_CNT_MSB   = 31;
  localparam int STAT_VALID_BIT = 32;
  localparam int STAT_ERR_BIT   = 33;

  // Status word: upper bits zero, error flag, always-set valid flag, block count.
  function automatic logic [127:0] stat_word(input logic err, input logic [31:0] cnt);
    logic [127:0] w;
    w = '0;
    w[STAT_CNT_MSB:STAT_CNT_LSB] = cnt;
    w[STAT_VALID_BIT]            = 1'b1;
    w[STAT_ERR_BIT]              = err;
    return w;
  endfunction

endpackage

// File: rtl/aes_mem_timeout.sv
// Watchdog counter: held at zero while load is high, counts while enabled,
// and saturates at LIMIT-1 where expired is raised.
module aes_mem_timeout #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == W'(LIMIT - 1));

  // Next count: clear on load, otherwise advance until the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/aes_mem_master.sv
// Fetches key and plaintext from a dual-port memory, hands them to an AES core,
// writes back the ciphertext and a status word. All outputs are registered.
module aes_mem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] AES_BE         = 16'hFFFF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [1:0]   mem_address,
  output logic         mem_chipselect,
  output logic         mem_write,
  output logic [15:0]  mem_byteenable,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  output logic         mem_clken,
  output logic [127:0] aes_key,
  output logic [127:0] aes_din,
  output logic         aes_in_valid,
  input  logic         aes_in_ready,
  input  logic [127:0] aes_dout,
  input  logic         aes_out_valid
);
  import aes_mem_pkg::*;

  state_e        state_q, state_d;
  logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic          in_valid_q, in_valid_d, cs_q, cs_d, wr_q, wr_d, clken_q;
  logic [1:0]    addr_q, addr_d;
  logic [127:0]  wdata_q, wdata_d, key_q, key_d, pt_q, pt_d;
  logic [31:0]   block_count_q, block_count_d;
  logic          tmo_expired;

  aes_mem_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state_q != CORE_WAIT),
    .en      (state_q == CORE_WAIT),
    .expired (tmo_expired)
  );

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = error_q;
    in_valid_d    = 1'b0;
    cs_d          = 1'b0;
    wr_d          = 1'b0;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    key_d         = key_q;
    pt_d          = pt_q;
    block_count_d = block_count_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RD_KEY; busy_d = 1'b1; error_d = 1'b0;
        cs_d = 1'b1; addr_d = ADDR_KEY;
      end
      RD_KEY: begin
        state_d = RD_PT; cs_d = 1'b1; addr_d = ADDR_PT;
      end
      // Read data arrives one cycle after the request.
      RD_PT: begin
        key_d = mem_readdata; state_d = CAP_PT;
      end
      CAP_PT: begin
        pt_d = mem_readdata; state_d = CORE_REQ; in_valid_d = 1'b1;
      end
      CORE_REQ: begin
        if (aes_in_ready) state_d = CORE_WAIT;
        else              in_valid_d = 1'b1;
      end
      // A result arriving in the expiry cycle still counts as success.
      CORE_WAIT: begin
        if (aes_out_valid) begin
          block_count_d = block_count_q + 32'd1;
          state_d = WR_CT; cs_d = 1'b1; wr_d = 1'b1;
          addr_d = ADDR_CT; wdata_d = aes_dout;
        end else if (tmo_expired) begin
          error_d = 1'b1;
          state_d = WR_STAT; cs_d = 1'b1; wr_d = 1'b1;
          addr_d = ADDR_STAT; wdata_d = stat_word(1'b1, block_count_q);
        end
      end
      WR_CT: begin
        state_d = WR_STAT; cs_d = 1'b1; wr_d = 1'b1;
        addr_d = ADDR_STAT; wdata_d = stat_word(error_q, block_count_q);
      end
      WR_STAT: begin
        state_d = DONE; done_d = 1'b1; busy_d = 1'b0;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM and output registers; reset aborts any transaction with no access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      in_valid_q    <= 1'b0;
      cs_q          <= 1'b0;
      wr_q          <= 1'b0;
      clken_q       <= 1'b0;
      addr_q        <= 2'd0;
      wdata_q       <= '0;
      key_q         <= '0;
      pt_q          <= '0;
      block_count_q <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      in_valid_q    <= in_valid_d;
      cs_q          <= cs_d;
      wr_q          <= wr_d;
      clken_q       <= 1'b1;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      key_q         <= key_d;
      pt_q          <= pt_d;
      block_count_q <= block_count_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign mem_address    = addr_q;
  assign mem_chipselect = cs_q;
  assign mem_write      = wr_q;
  assign mem_byteenable = AES_BE;
  assign mem_writedata  = wdata_q;
  assign mem_clken      = clken_q;
  assign aes_key        = key_q;
  assign aes_din        = pt_q;
  assign aes_in_valid   = in_valid_q;

endmodule

// File: tb/tb_aes_mem_master.sv
// Randomized bench for aes_mem_master: behavioural memory and AES core models,
// per-block expectations derived from the word map and status layout.
module tb_aes_mem_master;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         start = 1'b0;
  logic         busy, done, error, mem_chipselect, mem_write, mem_clken, aes_in_valid;
  logic [1:0]   mem_address;
  logic [15:0]  mem_byteenable;
  logic [127:0] mem_writedata, aes_key, aes_din;
  logic [127:0] mem_readdata;
  logic         aes_in_ready, aes_out_valid;
  logic [127:0] aes_dout;

  aes_mem_master #(.TIMEOUT_CYCLES(16), .AES_BE(16'hFFFF)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .error(error),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_clken(mem_clken), .aes_key(aes_key), .aes_din(aes_din),
    .aes_in_valid(aes_in_valid), .aes_in_ready(aes_in_ready), .aes_dout(aes_dout),
    .aes_out_valid(aes_out_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // Stand-in cipher: the known FIPS-197 vector, otherwise a keyed scramble.
  function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return {p[63:0], p[127:64]} ^ {k[0], k[127:1]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: latency-1 reads, byte-enabled writes, write log, backdoor load.
  logic [127:0] mem [4];
  logic         ld_en = 1'b0;
  logic [1:0]   ld_addr = 2'd0;
  logic [127:0] ld_data = '0;
  int wr2_n = 0, wr3_n = 0, wr2_cyc = 0, wr3_cyc = 0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (mem_chipselect && mem_write) begin
      for (int b = 0; b < 16; b++)
        if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      if (mem_address == 2'd2) begin wr2_n <= wr2_n + 1; wr2_cyc <= cyc; end
      if (mem_address == 2'd3) begin wr3_n <= wr3_n + 1; wr3_cyc <= cyc; end
    end
    if (mem_chipselect && !mem_write) mem_readdata <= mem[mem_address];
  end

  // AES core model: ready after cfg_stall waiting cycles, result cfg_lat cycles later.
  int           cfg_stall = 0, cfg_lat = 1;
  bit           cfg_never = 1'b0;
  int           vld_run = 0, core_cnt = 0, xfer_n = 0, xfer_cyc = 0;
  bit           core_pend = 1'b0;
  logic         core_vld = 1'b0;
  logic [127:0] core_dout = '0, seen_key = '0, seen_din = '0;
  logic         spur_vld = 1'b0;
  logic [127:0] spur_dout = '0;

  assign aes_in_ready  = (vld_run >= cfg_stall);
  assign aes_out_valid = core_vld | spur_vld;
  assign aes_dout      = core_vld ? core_dout : spur_dout;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_vld <= 1'b0; core_pend <= 1'b0; core_cnt <= 0; vld_run <= 0;
    end else begin
      core_vld <= 1'b0;
      if (aes_in_valid && !aes_in_ready) vld_run <= vld_run + 1;
      else                               vld_run <= 0;
      if (aes_in_valid && aes_in_ready) begin
        xfer_n <= xfer_n + 1; xfer_cyc <= cyc;
        seen_key <= aes_key; seen_din <= aes_din;
        core_dout <= enc(aes_key, aes_din);
        core_pend <= !cfg_never; core_cnt <= cfg_lat;
      end else if (core_pend) begin
        if (core_cnt <= 1) begin core_vld <= 1'b1; core_pend <= 1'b0; end
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // Observation of pulses and the request window, sampled mid-cycle.
  int           done_n = 0, done_cyc = 0, ov_cyc = 0, vld_first_cyc = 0, vld_len = 0, din_unstable = 0;
  logic         vld_prev = 1'b0;
  logic [127:0] vld_din0 = '0;

  always @(negedge clk) begin
    if (done) begin done_n++; done_cyc = cyc; end
    if (core_vld) ov_cyc = cyc;
    if (aes_in_valid) begin
      if (!vld_prev) begin vld_first_cyc = cyc; vld_din0 = aes_din; vld_len = 0; end
      vld_len++;
      if (aes_din !== vld_din0) din_unstable++;
    end
    vld_prev = aes_in_valid;
  end

  // Reference state: expected ciphertext word and block count.
  logic [127:0] m_ct;
  logic [31:0]  m_count = '0;

  task automatic load(input logic [1:0] a, input logic [127:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_invld"}, aes_in_valid, 0);
    chk({tag, "_cs"}, mem_chipselect, 0);
    chk({tag, "_wr"}, mem_write, 0);
    chk({tag, "_clken"}, mem_clken, 0);
    chk({tag, "_addr"}, mem_address, 0);
    chk({tag, "_key"}, aes_key, 0);
    chk({tag, "_din"}, aes_din, 0);
    chk({tag, "_wdata"}, mem_writedata, 0);
  endtask

  task automatic run_block(input logic [127:0] k, input logic [127:0] p, input int stall,
                           input int lat, input bit never, input bit restart, input bit spur);
    int w2, w3, d0, x0, u0, c0, t;
    bit pulsed, spurd;
    pulsed = 1'b0; spurd = 1'b0;
    load(2'd0, k); load(2'd1, p);
    cfg_stall = stall; cfg_lat = lat; cfg_never = never;
    w2 = wr2_n; w3 = wr3_n; d0 = done_n; x0 = xfer_n; u0 = din_unstable;
    start = 1'b1; c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", busy, 1);
    chk("err_clr", error, 0);
    t = 0;
    while (done_n == d0 && t < 300) begin
      spur_vld = 1'b0; start = 1'b0;
      if (restart && !pulsed && xfer_n != x0) begin start = 1'b1; pulsed = 1'b1; end
      if (spur && !spurd && aes_in_valid && !aes_in_ready) begin
        spur_vld = 1'b1; spur_dout = rnd128(); spurd = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    spur_vld = 1'b0; start = 1'b0;
    if (!never) begin m_count = m_count + 32'd1; m_ct = enc(k, p); end
    repeat (3) @(negedge clk);
    chk("done_cnt", done_n - d0, 1);
    chk("xfer_cnt", xfer_n - x0, 1);
    chk("busy_off", busy, 0);
    chk("error", error, never);
    chk("in_lat", vld_first_cyc, c0 + 4);
    chk("in_len", vld_len, stall + 1);
    chk("din_stable", din_unstable - u0, 0);
    chk("key_out", seen_key, k);
    chk("din_out", seen_din, p);
    chk("ct_word", mem[2], m_ct);
    chk("stat_word", mem[3], {94'b0, never, 1'b1, m_count});
    chk("ct_writes", wr2_n - w2, never ? 0 : 1);
    chk("stat_writes", wr3_n - w3, 1);
    if (never) chk("tmo_lat", wr3_cyc, xfer_cyc + 17);
    else       chk("ct_lat", wr2_cyc, ov_cyc + 1);
    chk("done_lat", done_cyc, wr3_cyc + 1);
  endtask

  initial begin
    int w2, w3, x0, t;
    logic [127:0] k, p;

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    m_ct = rnd128();
    load(2'd2, m_ct);
    load(2'd3, rnd128());
    reset_n = 1'b1;
    @(negedge clk);
    chk("clken_on", mem_clken, 1);

    // Known-answer block.
    run_block(FIPS_KEY, FIPS_PT, 0, 10, 1'b0, 1'b0, 1'b0);
    chk("fips_ct", mem[2], FIPS_CT);
    // Core never answers.
    run_block(rnd128(), rnd128(), 0, 1, 1'b1, 1'b0, 1'b0);
    // Stalled handshake with a stray result pulse during the stall.
    run_block(rnd128(), rnd128(), 5, 3, 1'b0, 1'b0, 1'b1);
    // Result lands exactly in the expiry cycle, and one cycle later.
    run_block(rnd128(), rnd128(), 0, 15, 1'b0, 1'b0, 1'b0);
    run_block(rnd128(), rnd128(), 0, 16, 1'b1, 1'b0, 1'b0);
    // Start pulsed while waiting on the core.
    run_block(rnd128(), rnd128(), 1, 8, 1'b0, 1'b1, 1'b0);

    // Stray result while idle.
    w2 = wr2_n; w3 = wr3_n;
    spur_vld = 1'b1; spur_dout = rnd128();
    @(negedge clk);
    spur_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_busy", busy, 0);
    chk("spur_writes", (wr2_n - w2) + (wr3_n - w3), 0);

    // Reset while waiting on the core.
    k = rnd128(); p = rnd128();
    load(2'd0, k); load(2'd1, p);
    cfg_never = 1'b1; cfg_stall = 0;
    w2 = wr2_n; w3 = wr3_n; x0 = xfer_n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (xfer_n == x0 && t < 50) begin @(negedge clk); t++; end
    chk("rst_xfer", xfer_n - x0, 1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset("mid");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_count = '0;
    repeat (2) @(negedge clk);
    chk("rst_no_ct", wr2_n - w2, 0);
    chk("rst_no_stat", wr3_n - w3, 0);
    chk("rst_ct_keep", mem[2], m_ct);
    run_block(rnd128(), rnd128(), 0, 4, 1'b0, 1'b0, 1'b0);

    // Count wrap.
    force dut.block_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.block_count_q;
    m_count = 32'hFFFF_FFFF;
    run_block(rnd128(), rnd128(), 0, 2, 1'b0, 1'b0, 1'b0);
    chk("wrap_cnt", mem[3][31:0], 32'd0);

    // Random blocks.
    for (int i = 0; i < 20; i++)
      run_block(rnd128(), rnd128(), $urandom_range(0, 3), $urandom_range(1, 15),
                ($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
